// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared state type and parameter defaults for the waveform analyzer
package waveform_pkg;

   localparam int         CNT_W_DEF  = 16;
   localparam logic [7:0] THRESH_DEF = 8'h80;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      ARM,
      MEASURE,
      DONE
   } state_t;

endpackage

// File: rtl/wave_edge_detect.sv
// rtl/wave_edge_detect.sv - threshold decode and rising-crossing detect against the previous accepted sample
module wave_edge_detect
   import waveform_pkg::*;
#(
   parameter logic [7:0] THRESH = THRESH_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       update,
   input  logic [7:0] sample,
   output logic       high,
   output logic       rise
);

   // Only the thresholded level of the previous sample matters for crossing detection.
   logic prev_high;

   assign high = (sample >= THRESH);
   assign rise = high && !prev_high;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_high <= 1'b0;
      end else if (update) begin
         prev_high <= high;
      end
   end

endmodule

// File: rtl/waveform_analyzer.sv
// rtl/waveform_analyzer.sv - measures period, high time and extremes between two rising threshold crossings
module waveform_analyzer
   import waveform_pkg::*;
#(
   parameter int         CNT_W  = CNT_W_DEF,
   parameter logic [7:0] THRESH = THRESH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sample_valid,
   input  logic [7:0]       sample,
   output logic             busy,
   output logic             result_valid,
   output logic             timeout,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_count,
   output logic [7:0]       max_val,
   output logic [7:0]       min_val
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic             high, rise, track;
   logic             arm_to, meas_to, capture;
   logic [CNT_W-1:0] wait_cnt, cnt, hcnt;
   logic [7:0]       wmax, wmin;

   assign track = sample_valid && (state == PRIME || state == ARM || state == MEASURE);

   wave_edge_detect #(.THRESH(THRESH)) u_edge (
      .clk    (clk),
      .rst    (rst),
      .update (track),
      .sample (sample),
      .high   (high),
      .rise   (rise)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arm_to    = 1'b0;
      meas_to   = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE:    if (start) state_nxt = PRIME;
         PRIME:   if (sample_valid) state_nxt = ARM;
         ARM: begin
            if (sample_valid) begin
               if (rise) begin
                  state_nxt = MEASURE;
               end else if (wait_cnt == CNT_MAX - 1'b1) begin
                  arm_to    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         MEASURE: begin
            if (sample_valid) begin
               if (rise) begin
                  capture   = 1'b1;
                  state_nxt = DONE;
               end else if (cnt == CNT_MAX) begin
                  meas_to   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign result_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout    <= 1'b0;
         wait_cnt   <= '0;
         cnt        <= '0;
         hcnt       <= '0;
         wmax       <= 8'h00;
         wmin       <= 8'hFF;
         period     <= '0;
         high_count <= '0;
         max_val    <= 8'h00;
         min_val    <= 8'hFF;
      end else begin
         timeout <= arm_to || meas_to;
         if (state == IDLE) wait_cnt <= '0;
         if (state == ARM && sample_valid) begin
            if (rise) begin
               cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
               hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
               wmax <= sample;
               wmin <= sample;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
         // The terminating crossing sample is excluded from the reported window.
         if (capture) begin
            period     <= cnt;
            high_count <= hcnt;
            max_val    <= wmax;
            min_val    <= wmin;
         end else if (state == MEASURE && sample_valid && !meas_to) begin
            cnt  <= cnt + 1'b1;
            hcnt <= hcnt + {{(CNT_W-1){1'b0}}, high};
            if (sample > wmax) wmax <= sample;
            if (sample < wmin) wmin <= sample;
         end
      end
   end

endmodule

// File: tb/tb_waveform_analyzer.sv
// tb/tb_waveform_analyzer.sv - directed and randomized self-checking bench for waveform_analyzer
module tb_waveform_analyzer;
   import waveform_pkg::*;

   localparam int CNT_W = 16;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, start, sample_valid;
   logic [7:0]       sample;
   logic             busy, result_valid, timeout;
   logic [CNT_W-1:0] period, high_count;
   logic [7:0]       max_val, min_val;

   int n_assert = 0;
   int n_fail   = 0;

   logic [CNT_W-1:0] held_p, held_h;
   logic [7:0]       held_mx, held_mn;
   logic [7:0]       rnd [2048];

   waveform_analyzer #(.CNT_W(CNT_W), .THRESH(8'h80)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sample_valid (sample_valid),
      .sample       (sample),
      .busy         (busy),
      .result_valid (result_valid),
      .timeout      (timeout),
      .period       (period),
      .high_count   (high_count),
      .max_val      (max_val),
      .min_val      (min_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag, input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h,
                                input logic [7:0] mx, input logic [7:0] mn);
      check({tag, ".period"}, 32'(period), 32'(p));
      check({tag, ".high_count"}, 32'(high_count), 32'(h));
      check({tag, ".max_val"}, 32'(max_val), 32'(mx));
      check({tag, ".min_val"}, 32'(min_val), 32'(mn));
   endtask

   function automatic logic [7:0] gen(input int kind, input int i);
      int p;
      case (kind)
         0: gen = ((i / 256) % 2 == 0) ? 8'h7F : 8'hFF;
         1: begin
            p = i % 512;
            gen = (p < 256) ? 8'(p) : 8'(511 - p);
         end
         2: gen = ((i % 512) < 128) ? 8'hFF : 8'h7F;
         3: gen = 8'h00;
         default: gen = rnd[i % 2048];
      endcase
   endfunction

   function automatic bit is_high(input logic [7:0] s);
      return s >= 8'h80;
   endfunction

   function automatic bit crossing(input int kind, input int i);
      return is_high(gen(kind, i)) && !is_high(gen(kind, i - 1));
   endfunction

   // Index 0 of the accepted stream primes prev; the window runs from the first crossing
   // up to (not including) the next one, or ends in a timeout when a counter saturates.
   task automatic model(input int kind, output bit to, output int last,
                        output logic [CNT_W-1:0] p, output logic [CNT_W-1:0] h,
                        output logic [7:0] mx, output logic [7:0] mn);
      int s, j, hc;
      to = 0; last = 0; p = held_p; h = held_h; mx = held_mx; mn = held_mn;
      s = 0;
      for (int i = 1; s == 0; i++) begin
         if (crossing(kind, i)) s = i;
         else if (i == MAXC) begin
            to = 1; last = i; return;
         end
      end
      hc = 0;
      mx = gen(kind, s); mn = gen(kind, s);
      for (j = s; ; j++) begin
         if (j > s && crossing(kind, j)) begin
            last = j; p = CNT_W'(j - s); h = CNT_W'(hc); return;
         end
         if (j - s == MAXC) begin
            to = 1; last = j; mx = held_mx; mn = held_mn; return;
         end
         if (is_high(gen(kind, j))) hc++;
         if (gen(kind, j) > mx) mx = gen(kind, j);
         if (gen(kind, j) < mn) mn = gen(kind, j);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = 8'h00;
      @(posedge clk); #1;
      check({tag, ".busy"}, 32'(busy), 0);
      check({tag, ".result_valid"}, 32'(result_valid), 0);
      check({tag, ".timeout"}, 32'(timeout), 0);
      check_results(tag, '0, '0, 8'h00, 8'hFF);
      rst = 1'b0;
      held_p = '0; held_h = '0; held_mx = 8'h00; held_mn = 8'hFF;
   endtask

   // vmode: 0 always valid, 1 toggling valid, 2 random valid with stray start pulses
   task automatic run(input string tag, input int kind, input int vmode, input int budget, input int abort_at);
      bit to_exp, done, v;
      int last, idx, cyc, last_acc;
      logic [CNT_W-1:0] ep, eh;
      logic [7:0] emx, emn;
      model(kind, to_exp, last, ep, eh, emx, emn);
      start = 1'b1; sample_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".busy_after_start"}, 32'(busy), 1);
      idx = 0; cyc = 0; done = 0; last_acc = -1;
      while (!done && cyc < budget && !(abort_at > 0 && cyc == abort_at)) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 1);
            default: v = ($urandom % 4) != 0;
         endcase
         start        = (vmode == 2) && ($urandom % 16 == 0);
         sample_valid = v;
         sample       = gen(kind, idx);
         @(posedge clk);
         if (v) begin
            idx++;
            last_acc = cyc;
         end
         #1;
         check({tag, ".exclusive"}, 32'(result_valid && timeout), 0);
         if (result_valid || timeout) begin
            done = 1;
            check({tag, ".kind_timeout"}, 32'(timeout), 32'(to_exp));
            check({tag, ".kind_result"}, 32'(result_valid), 32'(!to_exp));
            check({tag, ".accepted"}, 32'(idx), 32'(last + 1));
            check({tag, ".latency"}, 32'(last_acc), 32'(cyc));
            if (to_exp) check({tag, ".busy_at_timeout"}, 32'(busy), 0);
            check_results({tag, ".res"}, ep, eh, emx, emn);
            held_p = ep; held_h = eh; held_mx = emx; held_mn = emn;
         end else begin
            check_results({tag, ".hold"}, held_p, held_h, held_mx, held_mn);
         end
         cyc++;
      end
      start = 1'b0; sample_valid = 1'b0;
      if (abort_at > 0 && !done) return;
      if (!done) check({tag, ".budget_expired"}, 0, 1);
      @(posedge clk); #1;
      check({tag, ".pulse_end_rv"}, 32'(result_valid), 0);
      check({tag, ".pulse_end_to"}, 32'(timeout), 0);
      check({tag, ".idle_after"}, 32'(busy), 0);
   endtask

   task automatic fill_random();
      int pos, len;
      bit lvl;
      pos = 0;
      lvl = 1'($urandom % 2);
      while (pos < 2048) begin
         len = $urandom_range(1, 40);
         for (int k = 0; k < len && pos < 2048; k++) begin
            rnd[pos] = lvl ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
            pos++;
         end
         lvl = !lvl;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = 8'h00;
      @(posedge clk);
      do_reset("reset");

      run("square", 0, 0, 5000, 0);
      run("triangle", 1, 0, 5000, 0);
      run("pwm", 2, 0, 5000, 0);
      run("square_toggle", 0, 1, 5000, 0);

      for (int r = 0; r < 4; r++) begin
         fill_random();
         run($sformatf("random%0d", r), 4, 2, 5000, 0);
      end

      run("const0_timeout", 3, 0, 70000, 0);

      run("abort", 0, 0, 5000, 600);
      do_reset("mid_reset");
      @(posedge clk); #1;
      check("abort.no_rv", 32'(result_valid), 0);
      check("abort.no_to", 32'(timeout), 0);
      run("after_abort", 0, 0, 5000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
